// File: rtl/uart_rx_edge_sampler_if.sv
// uart_rx_edge_sampler_if
//   Bundles the UART receiver front-end signals between the receive FSM side
//   (master) and the edge sampler (slave). Signal prefixes are taken from the
//   sampler's point of view: i_ = into the sampler, o_ = out of the sampler.
//
//   i_s_data       raw serial line, asynchronous, idles high
//   i_prescale     oversampling ratio (8/16/32 legal), static while enabled
//   i_enable       edge/bit counting enable
//   i_samp_en      sampling enable
//   o_rx_sync      synchronized serial line
//   o_edge_count   oversample index within current bit
//   o_bit_count    current frame bit index, saturating at 15
//   o_sampled_bit  majority-voted value of the most recent bit
//   o_sample_valid one-cycle pulse when o_sampled_bit is updated
//   o_start_glitch one-cycle pulse on a false start bit
interface uart_rx_edge_sampler_if #(
  parameter int unsigned P_W = 6
);
  logic           i_s_data;
  logic [P_W-1:0] i_prescale;
  logic           i_enable;
  logic           i_samp_en;
  logic           o_rx_sync;
  logic [P_W-1:0] o_edge_count;
  logic [3:0]     o_bit_count;
  logic           o_sampled_bit;
  logic           o_sample_valid;
  logic           o_start_glitch;

  modport master (
    output i_s_data, i_prescale, i_enable, i_samp_en,
    input  o_rx_sync, o_edge_count, o_bit_count, o_sampled_bit, o_sample_valid,
           o_start_glitch
  );

  modport slave (
    input  i_s_data, i_prescale, i_enable, i_samp_en,
    output o_rx_sync, o_edge_count, o_bit_count, o_sampled_bit, o_sample_valid,
           o_start_glitch
  );
endinterface

// File: rtl/uart_rx_edge_sampler.sv
// uart_rx_edge_sampler
//   Front-end timing stage of the UART receiver: 2-flop synchronizer on the
//   serial line, oversampling edge counter, saturating bit counter and a
//   3-sample majority vote around the middle of each bit.
//
//   CLK     oversampling clock, rising edge
//   RST     asynchronous active-low reset
//   io_bus  slave side of uart_rx_edge_sampler_if (see interface header)
module uart_rx_edge_sampler #(
  parameter int unsigned P_W = 6
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_edge_sampler_if.slave io_bus
);

  localparam logic [P_W-1:0] MinP = P_W'(8);

  logic [P_W-1:0] w_p;
  logic [P_W-1:0] w_last;
  logic [P_W-1:0] w_half;
  logic           w_samp;
  logic           w_at_s0;
  logic           w_at_s1;
  logic           w_at_dec;
  logic           w_majority;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_s0;
  logic           r_s1;
  logic [P_W-1:0] r_edge_count;
  logic [3:0]     r_bit_count;
  logic           r_sampled_bit;
  logic           r_sample_valid;
  logic           r_start_glitch;

  // Effective ratio: clamp to 8 and force even so the half point is exact.
  always_comb begin
    if (io_bus.i_prescale < MinP) begin
      w_p = MinP;
    end else begin
      w_p = {io_bus.i_prescale[P_W-1:1], 1'b0};
    end
  end

  assign w_last = w_p - P_W'(1);
  assign w_half = w_p >> 1;

  assign w_samp   = io_bus.i_enable & io_bus.i_samp_en;
  assign w_at_s0  = w_samp && (r_edge_count == (w_half - P_W'(2)));
  assign w_at_s1  = w_samp && (r_edge_count == (w_half - P_W'(1)));
  assign w_at_dec = w_samp && (r_edge_count == w_half);

  // Third vote is the live synchronized line at the decision edge.
  assign w_majority = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_edge_count   <= '0;
      r_bit_count    <= '0;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
      r_start_glitch <= 1'b0;
    end else begin
      r_sync1 <= io_bus.i_s_data;
      r_sync2 <= r_sync1;

      if (!io_bus.i_enable) begin
        r_edge_count <= '0;
        r_bit_count  <= '0;
      end else if (r_edge_count >= w_last) begin
        // >= keeps the counter from running away if it ever exceeds P-1.
        r_edge_count <= '0;
        if (r_bit_count != 4'hF) begin
          r_bit_count <= r_bit_count + 4'd1;
        end
      end else begin
        r_edge_count <= r_edge_count + P_W'(1);
      end

      if (w_at_s0) begin
        r_s0 <= r_sync2;
      end
      if (w_at_s1) begin
        r_s1 <= r_sync2;
      end
      if (w_at_dec) begin
        r_sampled_bit <= w_majority;
      end
      r_sample_valid <= w_at_dec;
      r_start_glitch <= w_at_dec && (r_bit_count == 4'd0) && w_majority;
    end
  end

  assign io_bus.o_rx_sync      = r_sync2;
  assign io_bus.o_edge_count   = r_edge_count;
  assign io_bus.o_bit_count    = r_bit_count;
  assign io_bus.o_sampled_bit  = r_sampled_bit;
  assign io_bus.o_sample_valid = r_sample_valid;
  assign io_bus.o_start_glitch = r_start_glitch;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// tb_uart_rx_edge_sampler
//   Randomized and directed stimulus for uart_rx_edge_sampler, checked every
//   cycle against a cycle-count based reference model, plus literal checks of
//   the directed scenarios.
module tb_uart_rx_edge_sampler;

  localparam int P_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_edge_sampler_if #(.P_W(P_W)) bus ();

  uart_rx_edge_sampler #(.P_W(P_W)) dut (
    .CLK   (clk),
    .RST   (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int eff_p(input int ps);
    if (ps < 8) return 8;
    return ps - (ps % 2);
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Reference model: m_n counts consecutive enabled edges since enable rose;
  // edge/bit indices follow from it by division.
  int   m_n;
  int   x_edge;
  int   x_bitc;
  logic m_mid, m_rx, m_s0, m_s1, m_bit, m_valid, m_glitch;
  int   mp, me, mh, mb;
  logic m_capt, m_vote;

  always_comb begin
    mp     = eff_p(int'(bus.i_prescale));
    me     = m_n % mp;
    mh     = mp / 2;
    mb     = sat15(m_n / mp);
    m_capt = bus.i_enable && bus.i_samp_en;
    m_vote = (int'(m_s0) + int'(m_s1) + int'(m_rx)) >= 2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n      <= 0;
      x_edge   <= 0;
      x_bitc   <= 0;
      m_mid    <= 1'b1;
      m_rx     <= 1'b1;
      m_s0     <= 1'b1;
      m_s1     <= 1'b1;
      m_bit    <= 1'b1;
      m_valid  <= 1'b0;
      m_glitch <= 1'b0;
    end else begin
      m_valid  <= m_capt && (me == mh);
      m_glitch <= m_capt && (me == mh) && (mb == 0) && m_vote;
      if (m_capt && (me == mh - 2)) m_s0 <= m_rx;
      if (m_capt && (me == mh - 1)) m_s1 <= m_rx;
      if (m_capt && (me == mh)) m_bit <= m_vote;
      m_n    <= bus.i_enable ? m_n + 1 : 0;
      x_edge <= bus.i_enable ? (m_n + 1) % mp : 0;
      x_bitc <= bus.i_enable ? sat15((m_n + 1) / mp) : 0;
      m_mid  <= bus.i_s_data;
      m_rx   <= m_mid;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_sync",      int'(bus.o_rx_sync),      int'(m_rx));
      check("edge_count",   int'(bus.o_edge_count),   x_edge);
      check("bit_count",    int'(bus.o_bit_count),    x_bitc);
      check("sampled_bit",  int'(bus.o_sampled_bit),  int'(m_bit));
      check("sample_valid", int'(bus.o_sample_valid), int'(m_valid));
      check("start_glitch", int'(bus.o_start_glitch), int'(m_glitch));
    end
  end

  // Observation of DUT outputs for the directed literal checks.
  int   got_n;
  logic v_bit[$];
  int   v_bc[$];
  logic v_gl[$];
  int   max_bc;
  int   n_glitch;

  task automatic clear_mon();
    got_n    = 0;
    max_bc   = 0;
    n_glitch = 0;
    v_bit.delete();
    v_bc.delete();
    v_gl.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    if (bus.o_sample_valid) begin
      got_n++;
      v_bit.push_back(bus.o_sampled_bit);
      v_bc.push_back(int'(bus.o_bit_count));
      v_gl.push_back(bus.o_start_glitch);
    end
    if (int'(bus.o_bit_count) > max_bc) max_bc = int'(bus.o_bit_count);
    if (bus.o_start_glitch) n_glitch++;
  endtask

  task automatic idle(input int n);
    bus.i_enable  = 1'b0;
    bus.i_samp_en = 1'b0;
    bus.i_s_data  = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Start bit, 8 data bits LSB-first, stop bit; stops one cycle before bit 10.
  task automatic run_frame(input int p, input logic [7:0] data, output logic [9:0] bits);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    bus.i_prescale = P_W'(p);
    idle(4);
    clear_mon();
    bus.i_enable  = 1'b1;
    bus.i_samp_en = 1'b1;
    for (int c = 0; c < 10 * p - 1; c++) begin
      bus.i_s_data = frame[c / p];
      cyc();
    end
    bits = '0;
    for (int i = 0; i < 10 && i < v_bit.size(); i++) bits[i] = v_bit[i];
    idle(2);
  endtask

  logic [9:0] bits;
  int         prev_edge;
  int         wraps;
  int         found;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_s_data   = 1'b1;
    bus.i_prescale = P_W'(8);
    bus.i_enable   = 1'b0;
    bus.i_samp_en  = 1'b0;
    clear_mon();
    cyc();
    cmp_en = 1'b1;
    cyc();
    cyc();
    check("reset rx_sync",      int'(bus.o_rx_sync),      1);
    check("reset edge_count",   int'(bus.o_edge_count),   0);
    check("reset bit_count",    int'(bus.o_bit_count),    0);
    check("reset sampled_bit",  int'(bus.o_sampled_bit),  1);
    check("reset sample_valid", int'(bus.o_sample_valid), 0);
    check("reset start_glitch", int'(bus.o_start_glitch), 0);
    rst_n = 1'b1;
    idle(3);

    // Clean frame, P=8, 0xA5.
    run_frame(8, 8'hA5, bits);
    check("clean pulses", got_n, 10);
    check("clean bits", int'(bits), 'h34A);
    check("clean max bit_count", max_bc, 9);
    check("clean glitches", n_glitch, 0);

    // Start glitch, P=16: line low for only 3 cycles.
    bus.i_prescale = P_W'(16);
    idle(4);
    clear_mon();
    bus.i_enable  = 1'b1;
    bus.i_samp_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.i_s_data = (c < 3) ? 1'b0 : 1'b1;
      cyc();
    end
    check("glitch pulses", got_n, 1);
    if (got_n > 0) begin
      check("glitch bit_count", v_bc[0], 0);
      check("glitch sampled_bit", int'(v_bit[0]), 1);
      check("glitch coincident", int'(v_gl[0]), 1);
    end
    check("glitch count", n_glitch, 1);
    idle(4);

    // Noise rejection, P=16: data bit 1 with one, then two, samples forced low.
    for (int pass = 0; pass < 2; pass++) begin
      bus.i_prescale = P_W'(16);
      idle(4);
      clear_mon();
      bus.i_enable  = 1'b1;
      bus.i_samp_en = 1'b1;
      for (int c = 0; c < 31; c++) begin
        // Line value at iteration c reaches the sampler three edges later.
        if (c < 16) bus.i_s_data = 1'b0;
        else if (c == 21 || (pass == 1 && c == 20)) bus.i_s_data = 1'b0;
        else bus.i_s_data = 1'b1;
        cyc();
      end
      check("noise pulses", got_n, 2);
      if (got_n > 1) begin
        check("noise bit_count", v_bc[1], 1);
        check("noise sampled_bit", int'(v_bit[1]), (pass == 0) ? 1 : 0);
      end
      check("noise glitches", n_glitch, 0);
      idle(2);
    end

    // Enable drop mid-bit, P=8.
    bus.i_prescale = P_W'(8);
    idle(4);
    clear_mon();
    bus.i_enable  = 1'b1;
    bus.i_samp_en = 1'b1;
    bus.i_s_data  = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc();
      if (bus.o_edge_count == P_W'(2)) found = 1;
    end
    check("drop reached edge 2", found, 1);
    bus.i_enable = 1'b0;
    cyc();
    check("drop edge_count", int'(bus.o_edge_count), 0);
    check("drop bit_count", int'(bus.o_bit_count), 0);
    for (int i = 0; i < 10; i++) cyc();
    check("drop no sample", got_n, 0);
    idle(2);

    // P=32 wrap and saturation.
    bus.i_prescale = P_W'(32);
    idle(4);
    clear_mon();
    bus.i_enable = 1'b1;
    prev_edge = 0;
    wraps     = 0;
    for (int c = 0; c < 20 * 32; c++) begin
      cyc();
      if (prev_edge == 31 && bus.o_edge_count == P_W'(0)) wraps++;
      prev_edge = int'(bus.o_edge_count);
      if (c == 16 * 32 + 5) check("sat bit_count at 16 bits", int'(bus.o_bit_count), 15);
    end
    check("wrap count", wraps, 20);
    check("sat final bit_count", int'(bus.o_bit_count), 15);
    check("sat max bit_count", max_bc, 15);
    idle(2);

    // Async reset mid-frame at bit 4, edge 3.
    bus.i_prescale = P_W'(8);
    idle(4);
    bus.i_enable  = 1'b1;
    bus.i_samp_en = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      bus.i_s_data = (c < 8) ? 1'b0 : 1'b1;
      cyc();
      if (bus.o_bit_count == 4'd4 && bus.o_edge_count == P_W'(3)) found = 1;
    end
    check("reset point reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async rx_sync",      int'(bus.o_rx_sync),      1);
    check("async edge_count",   int'(bus.o_edge_count),   0);
    check("async bit_count",    int'(bus.o_bit_count),    0);
    check("async sampled_bit",  int'(bus.o_sampled_bit),  1);
    check("async sample_valid", int'(bus.o_sample_valid), 0);
    check("async start_glitch", int'(bus.o_start_glitch), 0);
    bus.i_enable  = 1'b0;
    bus.i_samp_en = 1'b0;
    cyc();
    rst_n = 1'b1;
    run_frame(8, 8'h3C, bits);
    check("post-reset pulses", got_n, 10);
    check("post-reset bits", int'(bits), 'h278);

    // Randomized frames with noise, samp_en gaps and occasional enable drops.
    for (int f = 0; f < 40; f++) begin
      int sel, ps, p, nb;
      logic v;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: ps = 8;
        1: ps = 16;
        2: ps = 32;
        3: ps = int'($urandom_range(0, 7));
        default: ps = int'($urandom_range(9, 40));
      endcase
      bus.i_prescale = P_W'(ps);
      idle(int'($urandom_range(1, 4)));
      p  = eff_p(ps);
      nb = int'($urandom_range(3, 11));
      bus.i_enable = 1'b1;
      for (int k = 0; k < nb; k++) begin
        v = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int j = 0; j < p; j++) begin
          bus.i_s_data  = ($urandom_range(0, 15) == 0) ? ~v : v;
          bus.i_samp_en = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 299) == 0) bus.i_enable = 1'b0;
          cyc();
        end
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
